// File: rtl/melody_player.sv
// Programmable piezo melody sequencer: plays a writable {half-period, length} note table
// as a square wave, with an articulation gap after each note and optional looping.
module melody_player #(
  parameter int PERIOD_W   = 16,
  parameter int LEN_W      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int UNIT_TICKS = 62500,
  parameter int GAP_TICKS  = 10000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [LEN_W-1:0]    wr_len,
  output logic                piezo_out,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   cur_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  localparam int UW = $clog2(UNIT_TICKS + 1);
  localparam int GW = $clog2(GAP_TICKS + 2);
  localparam logic [UW-1:0]     UNIT_LAST = UW'(UNIT_TICKS - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  logic [PERIOD_W-1:0] per_mem [DEPTH];
  logic [LEN_W-1:0]    len_mem [DEPTH];

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cur_idx_reg, cur_idx_next;
  logic                end_reg, end_next;      // index ran past DEPTH-1: next LOAD is an end marker
  logic [PERIOD_W-1:0] period_reg, period_next;
  logic [LEN_W-1:0]    units_reg, units_next;
  logic [UW-1:0]       unit_cnt_reg, unit_cnt_next;
  logic [PERIOD_W-1:0] tone_cnt_reg, tone_cnt_next;
  logic [GW-1:0]       gap_cnt_reg, gap_cnt_next;
  logic                piezo_reg, piezo_next;
  logic                done_reg, done_next;

  logic [PERIOD_W-1:0] rd_period;
  logic [LEN_W-1:0]    rd_len;
  logic                play_last;
  logic                adv_end;
  logic [ADDR_W-1:0]   adv_idx;

  // Table has no reset; writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      per_mem[wr_addr] <= wr_period;
      len_mem[wr_addr] <= wr_len;
    end
  end

  assign rd_period = per_mem[cur_idx_reg];
  assign rd_len    = len_mem[cur_idx_reg];
  assign play_last = (unit_cnt_reg == UNIT_LAST) && (units_reg == LEN_W'(1));
  assign adv_end   = (cur_idx_reg == IDX_LAST);
  assign adv_idx   = adv_end ? cur_idx_reg : cur_idx_reg + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cur_idx_reg  <= '0;
      end_reg      <= 1'b0;
      period_reg   <= '0;
      units_reg    <= '0;
      unit_cnt_reg <= '0;
      tone_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      piezo_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_idx_reg  <= cur_idx_next;
      end_reg      <= end_next;
      period_reg   <= period_next;
      units_reg    <= units_next;
      unit_cnt_reg <= unit_cnt_next;
      tone_cnt_reg <= tone_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      piezo_reg    <= piezo_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cur_idx_next  = cur_idx_reg;
    end_next      = end_reg;
    period_next   = period_reg;
    units_next    = units_reg;
    unit_cnt_next = unit_cnt_reg;
    tone_cnt_next = tone_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    piezo_next    = piezo_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        piezo_next = 1'b0;
        if (start && !stop) begin
          cur_idx_next = '0;
          end_next     = 1'b0;
          state_next   = LOAD;
        end
      end
      LOAD: begin
        if (end_reg || rd_len == '0) begin
          // Looping from entry 0 onto an end marker would spin forever, so that case completes.
          if (loop_en && (cur_idx_reg != '0 || end_reg)) begin
            cur_idx_next = '0;
            end_next     = 1'b0;
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end else begin
          period_next   = rd_period;
          units_next    = rd_len;
          unit_cnt_next = '0;
          tone_cnt_next = '0;
          piezo_next    = 1'b0;
          state_next    = PLAY;
        end
      end
      PLAY: begin
        if (period_reg != '0) begin
          if (tone_cnt_reg == period_reg - PERIOD_W'(1)) begin
            tone_cnt_next = '0;
            piezo_next    = ~piezo_reg;
          end else begin
            tone_cnt_next = tone_cnt_reg + PERIOD_W'(1);
          end
        end else begin
          piezo_next = 1'b0;
        end
        if (unit_cnt_reg == UNIT_LAST) begin
          unit_cnt_next = '0;
          units_next    = units_reg - LEN_W'(1);
        end else begin
          unit_cnt_next = unit_cnt_reg + UW'(1);
        end
        if (play_last) begin
          piezo_next = 1'b0;
          if (GAP_TICKS == 0) begin
            cur_idx_next = adv_idx;
            end_next     = adv_end;
            state_next   = LOAD;
          end else begin
            gap_cnt_next = '0;
            state_next   = GAP;
          end
        end
      end
      GAP: begin
        piezo_next = 1'b0;
        if (gap_cnt_reg == GAP_LAST) begin
          cur_idx_next = adv_idx;
          end_next     = adv_end;
          state_next   = LOAD;
        end else begin
          gap_cnt_next = gap_cnt_reg + GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (stop && state_reg != IDLE) begin
      state_next   = IDLE;
      piezo_next   = 1'b0;
      cur_idx_next = '0;
      end_next     = 1'b0;
      done_next    = 1'b0;
    end
  end

  assign piezo_out = piezo_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign cur_idx   = cur_idx_reg;

endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
Programmable piezo melody sequencer and the parametrised successor to the fixed-tune piezo driver. It holds a writable note table of DEPTH entries. Each entry is a tone half-period (0 = rest) plus a length in duration units (0 = end marker). On request it plays the table as a square wave, with an articulation gap between notes, and supports one-shot or loop mode. It sits between the game/control FSM, which loads the table and issues start/stop, and the board piezo pin. Default parameters target the 1 MHz system clock.

Parameters:
PERIOD_W, 16, width of tone half-period field in clk cycles (C4 = 1911 at 1 MHz)
LEN_W, 8, width of note length field in duration units
DEPTH, 16, number of note table entries
ADDR_W, 4, table address width; DEPTH <= 2**ADDR_W
UNIT_TICKS, 62500, clk cycles per duration unit (1/16 s at 1 MHz); must be >= 1
GAP_TICKS, 10000, silent clk cycles after each note; 0 = no gap

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to play from entry 0
stop  in  1  one-cycle request to abort playback
loop_en  in  1  1 = restart at entry 0 on end marker; sampled at each end marker
wr_en  in  1  note table write strobe
wr_addr  in  ADDR_W  write address
wr_period  in  PERIOD_W  half-period to write (0 = rest)
wr_len  in  LEN_W  length to write (0 = end marker)
piezo_out  out  1  square-wave output to piezo
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse on natural completion
cur_idx  out  ADDR_W  index of entry being loaded/played

Behaviour:
- Reset values: piezo_out=0, busy=0, done=0, cur_idx=0, state=IDLE. Table contents are undefined after reset; no clear.
- Table: synchronous write on wr_en, allowed in any state. A note's period and length are latched in LOAD, so rewriting the entry that is playing does not affect it. A rewrite of a later entry takes effect when that entry is loaded.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE: piezo_out=0. On start with stop=0: cur_idx<=0, go to LOAD, and busy rises the next cycle. If start and stop are both high, stop wins and the block stays IDLE.
- start while busy is ignored.
- stop while busy (any state): next cycle go to IDLE, piezo_out=0, busy=0, cur_idx=0. No done pulse.
- LOAD (exactly 1 cycle): read table[cur_idx].
  - If len==0 (end marker) and loop_en=1 and cur_idx!=0: cur_idx<=0, stay in LOAD.
  - If len==0 otherwise: pulse done, go to IDLE. An end marker at entry 0 means an empty melody, so done pulses 2 cycles after start.
  - Else: latch period/len, clear tone and unit counters, piezo_out<=0, go to PLAY.
- PLAY: lasts exactly len*UNIT_TICKS cycles, counted by a unit counter (0..UNIT_TICKS-1) and a remaining-units counter. No multiplier is used.
  - Tone: if period!=0, the tone counter runs 0..period-1 and piezo_out toggles when it wraps. First toggle is at PLAY cycle period-1 counted from 0, so the output half-period is period cycles.
  - If period==0 (rest): piezo_out held 0.
  - At the last cycle of the last unit: piezo_out<=0, go to GAP. If GAP_TICKS==0, advance the index and go to LOAD directly.
- GAP: piezo_out=0 for GAP_TICKS cycles, then advance the index and go to LOAD.
- Advance: if cur_idx==DEPTH-1, treat the next LOAD as an end marker (same loop/done rule, loop wraps to 0). Otherwise cur_idx+1. Index never exceeds DEPTH-1.
- Per-note time = 1 (LOAD) + len*UNIT_TICKS + GAP_TICKS cycles.
- done: exactly 1 cycle, coincident with the transition to IDLE. Never asserted in loop mode while loop_en stays 1.
- Reset mid-operation returns all outputs to reset values immediately (asynchronous).

Test Plan:
Use UNIT_TICKS=10, GAP_TICKS=2, DEPTH=4.
- Table {(3,2),(0,1),(5,1),(x,0)}, loop_en=0, start -> piezo toggles every 3 cycles for 20 cycles, 0 for 2; silent 10+2 (rest); toggles every 5 for 10, 0 for 2; done pulses once at cycle 1+22+1+12+1+12+1; busy falls with it.
- Same table, loop_en=1 -> after entry 3 marker, cur_idx returns to 0 and the pattern repeats. Clear loop_en mid-second pass -> done after the marker.
- Table entry 0 len=0, start -> busy high 1 cycle, done pulse 2 cycles after start, piezo stays 0.
- All 4 entries len=1 (no marker) -> plays 4 notes then done (index cap at DEPTH-1 acts as end).
- stop asserted mid-PLAY of entry 1 -> next cycle piezo_out=0, busy=0, cur_idx=0, no done. Simultaneous start+stop in IDLE -> stays IDLE.
- Rewrite entry 0 period during its PLAY -> current note keeps the old period. Assert rst mid-note -> outputs 0 asynchronously.
